// File: rtl/vga_fb_if.sv
// ---------------------------------------------------------------------------
// vga_fb_if
// Bus between the masking pipeline / scan-out (master) and the ping-pong
// frame store (slave).
//   write side : wr_valid, wr_ready, wr_row, wr_col, wr_pixel, wr_frame_done
//   read side  : rd_en, rd_row, rd_col, rd_frame_start, rd_pixel, rd_valid
//   status     : frame_swapped, oor_count (only with VGA_FB_OOR_COUNT_EN)
// ---------------------------------------------------------------------------
interface vga_fb_if #(
  parameter int PIX_W = 12,
  parameter int ROW_W = 8,
  parameter int COL_W = 9
) ();
  logic             wr_valid;
  logic             wr_ready;
  logic [ROW_W-1:0] wr_row;
  logic [COL_W-1:0] wr_col;
  logic [PIX_W-1:0] wr_pixel;
  logic             wr_frame_done;
  logic             rd_en;
  logic [ROW_W-1:0] rd_row;
  logic [COL_W-1:0] rd_col;
  logic             rd_frame_start;
  logic [PIX_W-1:0] rd_pixel;
  logic             rd_valid;
  logic             frame_swapped;
`ifdef VGA_FB_OOR_COUNT_EN
  logic [15:0]      oor_count;
`endif

  modport master (
`ifdef VGA_FB_OOR_COUNT_EN
    input  oor_count,
`endif
    output wr_valid, wr_row, wr_col, wr_pixel, wr_frame_done,
    output rd_en, rd_row, rd_col, rd_frame_start,
    input  wr_ready, rd_pixel, rd_valid, frame_swapped
  );

  modport slave (
`ifdef VGA_FB_OOR_COUNT_EN
    output oor_count,
`endif
    input  wr_valid, wr_row, wr_col, wr_pixel, wr_frame_done,
    input  rd_en, rd_row, rd_col, rd_frame_start,
    output wr_ready, rd_pixel, rd_valid, frame_swapped
  );
endinterface

// File: rtl/vga_frame_buffer_pp.sv
// ---------------------------------------------------------------------------
// vga_frame_buffer_pp
// Double-buffered frame store. The pipeline fills the back bank while
// scan-out reads the front bank; banks swap only at a display frame
// boundary so a partially written frame is never shown.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   fb     vga_fb_if slave modport (write handshake, registered reads,
//          swap pulse)
// Optional build macro: VGA_FB_OOR_COUNT_EN adds fb.oor_count, a saturating
// count of dropped out-of-range writes.
//
// state | meaning
// FILL  | back bank accepts writes; waiting for writer to finish frame
// HOLD  | frame complete, writes stalled until scan-out frame start
// ---------------------------------------------------------------------------
module vga_frame_buffer_pp #(
  parameter int PIX_W = 12,
  parameter int ROWS  = 240,
  parameter int COLS  = 320,
  parameter int ROW_W = 8,
  parameter int COL_W = 9
) (
  input  logic     clk,
  input  logic     rst_n,
  vga_fb_if.slave  fb
);

  localparam int DEPTH  = ROWS * COLS;
  localparam int ADDR_W = $clog2(2 * DEPTH);

  localparam logic [0:0] S_FILL = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  logic [0:0]       state_q, state_d;
  logic             wr_bank_q, wr_bank_d;
  logic             swap;
  logic             frame_swapped_q;
  logic [PIX_W-1:0] rd_pixel_q, rd_pixel_d;
  logic             rd_valid_q;

  logic [PIX_W-1:0] mem_q [2*DEPTH];

  logic [ROW_W-1:0] wr_row, rd_row;
  logic [COL_W-1:0] wr_col, rd_col;
  logic             wr_ready;
  logic             wr_fire;
  logic             wr_in_range, rd_in_range;
  logic [ADDR_W-1:0] wr_addr, rd_addr;

  assign wr_row = fb.wr_row;
  assign wr_col = fb.wr_col;
  assign rd_row = fb.rd_row;
  assign rd_col = fb.rd_col;

  assign wr_ready = (state_q == S_FILL);
  assign wr_fire  = fb.wr_valid && wr_ready;

  // 32-bit compares so ROWS/COLS equal to 2**ROW_W/2**COL_W still work
  assign wr_in_range = (32'(wr_row) < 32'(ROWS)) && (32'(wr_col) < 32'(COLS));
  assign rd_in_range = (32'(rd_row) < 32'(ROWS)) && (32'(rd_col) < 32'(COLS));

  // bank 1 occupies the upper DEPTH words; front bank is ~wr_bank_q
  assign wr_addr = (wr_bank_q ? ADDR_W'(DEPTH) : '0)
                 + ADDR_W'(wr_row) * ADDR_W'(COLS) + ADDR_W'(wr_col);
  assign rd_addr = (wr_bank_q ? '0 : ADDR_W'(DEPTH))
                 + ADDR_W'(rd_row) * ADDR_W'(COLS) + ADDR_W'(rd_col);

  always_comb begin
    state_d = state_q;
    swap    = 1'b0;
    case (state_q)
      S_FILL: begin
        if (fb.wr_frame_done) begin
          if (fb.rd_frame_start) swap    = 1'b1;
          else                   state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (fb.rd_frame_start) begin
          swap    = 1'b1;
          state_d = S_FILL;
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  assign wr_bank_d = wr_bank_q ^ swap;

  // read uses the pre-edge front bank, so a read in a swap cycle sees the old frame
  always_comb begin
    rd_pixel_d = rd_pixel_q;
    if (fb.rd_en) rd_pixel_d = rd_in_range ? mem_q[rd_addr] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_FILL;
      wr_bank_q       <= 1'b0;
      frame_swapped_q <= 1'b0;
      rd_pixel_q      <= '0;
      rd_valid_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      wr_bank_q       <= wr_bank_d;
      frame_swapped_q <= swap;
      rd_pixel_q      <= rd_pixel_d;
      rd_valid_q      <= fb.rd_en;
    end
  end

  // storage survives reset
  always_ff @(posedge clk) begin
    if (wr_fire && wr_in_range) mem_q[wr_addr] <= fb.wr_pixel;
  end

  assign fb.wr_ready      = wr_ready;
  assign fb.rd_pixel      = rd_pixel_q;
  assign fb.rd_valid      = rd_valid_q;
  assign fb.frame_swapped = frame_swapped_q;

`ifdef VGA_FB_OOR_COUNT_EN
  logic [15:0] oor_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oor_count_q <= '0;
    end else if (wr_fire && !wr_in_range && (oor_count_q != 16'hFFFF)) begin
      oor_count_q <= oor_count_q + 16'd1;
    end
  end

  assign fb.oor_count = oor_count_q;
`endif

endmodule
